// File: rtl/t05_histogram_responder.sv
// t05_histogram_responder: histogram store and compVal responder for the least-value finder (ports: en_state/char/eof count side, histo_index/compVal read side, node_valid/least1/least2/sum merge side, node_ptr/fin_state/sat_err status); define T05_HISTO_READ_BYPASS_EN for merge-write read bypass
module t05_histogram_responder #(
  parameter int CNT_W = 64,
  parameter int IDX_W = 9,
  parameter int LEAF_COUNT = 256,
  parameter int DEPTH = 512
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en_state,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  input  logic             eof,
  input  logic [IDX_W-1:0] histo_index,
  output logic [CNT_W-1:0] compVal,
  input  logic             node_valid,
  input  logic [IDX_W-1:0] least1,
  input  logic [IDX_W-1:0] least2,
  input  logic [CNT_W-1:0] sum,
  output logic [IDX_W:0]   node_ptr,
  output logic [3:0]       fin_state,
  output logic             sat_err
);
  typedef enum logic [1:0] {IDLE, COUNT, SERVE, DONE} state_t;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
  state_t state, state_nx;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] rd_val, base_val;
  logic counting, merging, merge_ok, w1, w2, cnt_sat;
  logic [IDX_W-1:0] cidx;
  always_comb begin
    state_nx = IDLE;
    if (state == COUNT && eof) state_nx = DONE;
    else if (en_state == 4'd1 && (state == IDLE || state == COUNT)) state_nx = COUNT;
    else if (en_state == 4'd2 && (state == IDLE || state == SERVE)) state_nx = SERVE;
  end
  assign cidx     = IDX_W'(char_in);
  assign counting = state == COUNT && char_valid;
  assign cnt_sat  = mem[cidx] == '1;
  assign merging  = state == SERVE && node_valid;
  assign merge_ok = merging && node_ptr != FULL;
  assign w1       = merge_ok && {1'b0, least1} < node_ptr;
  assign w2       = merge_ok && {1'b0, least2} < node_ptr;
  assign base_val = {1'b0, histo_index} < node_ptr ? mem[histo_index] : '0;
`ifdef T05_HISTO_READ_BYPASS_EN
  assign rd_val = merge_ok && {1'b0, histo_index} == node_ptr ? sum :
                  (w1 && histo_index == least1) || (w2 && histo_index == least2) ? '0 : base_val;
`else
  assign rd_val = base_val;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state     <= IDLE;
      compVal   <= '0;
      node_ptr  <= (IDX_W+1)'(LEAF_COUNT);
      fin_state <= '0;
      sat_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      compVal   <= state == SERVE ? rd_val : compVal;
      fin_state <= state == COUNT && eof ? 4'd1 : merge_ok ? 4'd2 : 4'd0;
      sat_err   <= sat_err | (counting && cnt_sat) | (merging && !merge_ok);
      if (counting && !cnt_sat) mem[cidx] <= mem[cidx] + 1'b1;
      if (w1) mem[least1] <= '0;
      if (w2) mem[least2] <= '0;
      if (merge_ok) begin
        mem[node_ptr[IDX_W-1:0]] <= sum;
        node_ptr <= node_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_t05_histogram_responder.sv
// tb_t05_histogram_responder: scoreboard bench for the histogram responder
module tb_t05_histogram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] en_state = '0;
  logic [7:0] char_in = '0;
  logic char_valid = 1'b0;
  logic eof = 1'b0;
  logic [8:0] histo_index = '0;
  logic [63:0] compVal;
  logic node_valid = 1'b0;
  logic [8:0] least1 = '0;
  logic [8:0] least2 = '0;
  logic [63:0] sum = '0;
  logic [9:0] node_ptr;
  logic [3:0] fin_state;
  logic sat_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];
  t05_histogram_responder dut (
    .clk(clk), .rst(rst), .en_state(en_state), .char_in(char_in),
    .char_valid(char_valid), .eof(eof), .histo_index(histo_index),
    .compVal(compVal), .node_valid(node_valid), .least1(least1),
    .least2(least2), .sum(sum), .node_ptr(node_ptr),
    .fin_state(fin_state), .sat_err(sat_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_rd(input string tag, input logic [63:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask
  task automatic pop_rd;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else check(tag_q.pop_front(), compVal, exp_q.pop_front());
  endtask
  task automatic rd(input string tag, input logic [8:0] idx, input logic [63:0] exp);
    histo_index = idx;
    expect_rd(tag, exp);
    tick();
    pop_rd();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    check("rst_compval", compVal, 0);
    check("rst_node_ptr", 64'(node_ptr), 256);
    check("rst_fin", 64'(fin_state), 0);
    check("rst_sat", 64'(sat_err), 0);
    rst = 1'b1;
    tick();
    en_state = 4'd1;
    tick();
    char_valid = 1'b1;
    char_in = 8'h41;
    repeat (3) tick();
    char_in = 8'h42;
    tick();
    char_valid = 1'b0;
    eof = 1'b1;
    tick();
    check("eof_fin1", 64'(fin_state), 1);
    eof = 1'b0;
    en_state = 4'd0;
    tick();
    check("eof_fin_once", 64'(fin_state), 0);
    en_state = 4'd1;
    tick();
    char_valid = 1'b1;
    char_in = 8'h43;
    eof = 1'b1;
    tick();
    check("cv_eof_fin1", 64'(fin_state), 1);
    char_valid = 1'b0;
    eof = 1'b0;
    en_state = 4'd0;
    tick();
    check("cv_eof_fin_once", 64'(fin_state), 0);
    en_state = 4'd2;
    tick();
    rd("rd_41", 9'h041, 3);
    rd("rd_42", 9'h042, 1);
    rd("rd_00", 9'h000, 0);
    rd("rd_43", 9'h043, 1);
    rd("rd_256_unwritten", 9'd256, 0);
    histo_index = 9'h041;
    node_valid = 1'b1;
    least1 = 9'h042;
    least2 = 9'h041;
    sum = 64'd4;
`ifdef T05_HISTO_READ_BYPASS_EN
    expect_rd("collision_41", 0);
`else
    expect_rd("collision_41", 3);
`endif
    tick();
    pop_rd();
    check("merge_node_ptr", 64'(node_ptr), 257);
    check("merge_fin2", 64'(fin_state), 2);
    node_valid = 1'b0;
    char_valid = 1'b1;
    char_in = 8'h42;
    rd("post_41", 9'h041, 0);
    check("merge_fin_once", 64'(fin_state), 0);
    char_valid = 1'b0;
    rd("post_42_no_serve_count", 9'h042, 0);
    rd("post_256", 9'd256, 4);
    rd("post_257", 9'd257, 0);
    least1 = 9'd0;
    least2 = 9'd0;
    node_valid = 1'b1;
    for (int i = 257; i < 512; i++) begin
      sum = 64'(1000 + i);
      tick();
    end
    node_valid = 1'b0;
    check("full_node_ptr", 64'(node_ptr), 512);
    check("full_sat_clear", 64'(sat_err), 0);
    node_valid = 1'b1;
    least1 = 9'd300;
    least2 = 9'h043;
    sum = 64'd77;
    tick();
    node_valid = 1'b0;
    check("drop_node_ptr", 64'(node_ptr), 512);
    check("drop_sat", 64'(sat_err), 1);
    check("drop_fin", 64'(fin_state), 0);
    rd("drop_keep_300", 9'd300, 1300);
    rd("drop_keep_43", 9'h043, 1);
    rd("drop_keep_511", 9'd511, 1511);
    rd("drop_keep_256", 9'd256, 4);
    en_state = 4'd0;
    tick();
    en_state = 4'd1;
    tick();
    char_valid = 1'b1;
    char_in = 8'h50;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("arst_compval", compVal, 0);
    check("arst_fin", 64'(fin_state), 0);
    check("arst_sat", 64'(sat_err), 0);
    check("arst_node_ptr", 64'(node_ptr), 256);
    char_valid = 1'b0;
    en_state = 4'd0;
    tick();
    rst = 1'b1;
    en_state = 4'd2;
    tick();
    rd("arst_rd_50", 9'h050, 0);
    rd("arst_rd_41", 9'h041, 0);
    rd("arst_rd_43", 9'h043, 0);
    rd("arst_rd_256", 9'd256, 0);
    rd("arst_rd_300", 9'd300, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
